nibble_serial_adder: RTL and testbench

Multi-cycle WIDTH-bit adder/subtractor built around one 4-bit carry-lookahead slice (`CLAA_1`). It feeds the slice one nibble per clock, least significant first, and chains the slice's carry-out through a register. It captures each 4-bit sum into a result register and reports carry, signed overflow and zero flags. It sits directly upstream of `CLAA_1`, supplying its `x`, `y` and `Cin`, and directly downstream of it, consuming `s` and `Cout`. Operands arrive and results leave over valid/ready handshakes.

---
 rtl/nibble_serial_adder.sv | 155 +++++++++++++++
 tb/tb_nibble_serial_adder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/sub through one 4-bit CLA slice, one nibble per clock.
// Ports: valid/ready operand input (a, b, sub), valid/ready result output (result, carry, ovf, zero).

module CLAA_1 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       Cin,
  output logic [3:0] s,
  output logic       Cout,
  output logic       Gij,
  output logic       Pij
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = x & y;
  assign p = x ^ y;

  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & Cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & Cin);

  assign Gij  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
  assign Pij  = &p;
  assign Cout = Gij | (Pij & Cin);
  assign s    = p ^ c;

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t st;
  state_t st_n;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_n;
  logic             cy_q;
  logic [IW-1:0]    idx;
  logic             ovf_q;
  logic             zero_q;

  logic [IW+1:0]    bit_lo;
  logic [3:0]       sx;
  logic [3:0]       sy;
  logic [3:0]       ss;
  logic             sco;
  logic             gij_unused;
  logic             pij_unused;
  logic             accept;
  logic             last;

  assign bit_lo = {idx, 2'b00};
  assign sx     = a_q[bit_lo +: 4];
  assign sy     = b_q[bit_lo +: 4];
  assign accept = (st == IDLE) && in_valid;
  assign last   = (idx == LAST);

  CLAA_1 u_slice (
    .x    (sx),
    .y    (sy),
    .Cin  (cy_q),
    .s    (ss),
    .Cout (sco),
    .Gij  (gij_unused),
    .Pij  (pij_unused)
  );

  always_comb begin
    res_n = res_q;
    res_n[bit_lo +: 4] = ss;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_n;
  end

  always_comb begin
    st_n = st;
    unique case (st)
      IDLE:    if (in_valid)  st_n = RUN;
      RUN:     if (last)      st_n = DONE;
      DONE:    if (out_ready) st_n = IDLE;
      default:                st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      cy_q   <= 1'b0;
      idx    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (accept) begin
      a_q  <= a;
      b_q  <= sub ? ~b : b;
      cy_q <= sub;
      idx  <= '0;
    end else if (st == RUN) begin
      res_q <= res_n;
      cy_q  <= sco;
      if (!last) idx <= idx + 1'b1;
      // Flags settle on the top-nibble edge so they hold through DONE.
      if (last) begin
        ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1])
               && (ss[3] != a_q[WIDTH-1]);
        zero_q <= (res_n == '0);
      end
    end
  end

  assign in_ready  = (st == IDLE);
  assign out_valid = (st == DONE);
  assign result    = res_q;
  assign carry     = cy_q & (st == DONE);
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder (WIDTH=16): vector table, handshake,
// reset-abort and random sweep, checked through an expected-result queue.

module tb_nibble_serial_adder;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry;
  logic         ovf;
  logic         zero;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] r;
    logic         c;
    logic         o;
    logic         z;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[8];

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [W-1:0] ta,
                                 input logic [W-1:0] tb_,
                                 input logic ts);
    vec_t v;
    logic [W-1:0] be;
    logic [W:0]   full;
    be    = ts ? ~tb_ : tb_;
    full  = {1'b0, ta} + {1'b0, be} + {{W{1'b0}}, ts};
    v.a   = ta;
    v.b   = tb_;
    v.sub = ts;
    v.r   = full[W-1:0];
    v.c   = full[W];
    v.o   = (ta[W-1] == be[W-1]) && (full[W-1] != ta[W-1]);
    v.z   = (full[W-1:0] == '0);
    return v;
  endfunction

  task automatic run_op(input vec_t v, input int hold, input bit noise);
    int   cyc;
    vec_t e;
    @(negedge clk);
    chk("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    a = v.a;
    b = v.b;
    sub = v.sub;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (noise) begin
      a = W'($urandom);
      b = W'($urandom);
      sub = 1'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    chk("in_ready_busy", in_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (noise && !out_valid) begin
        a = W'($urandom);
        b = W'($urandom);
      end
    end
    in_valid = 1'b0;
    chk("latency", cyc, N);
    e = sb.pop_front();
    if (!out_valid) return;
    chk("result", result, e.r);
    chk("carry", carry, e.c);
    chk("ovf", ovf, e.o);
    chk("zero", zero, e.z);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_result", {result, carry, ovf, zero},
          {e.r, e.c, e.o, e.z});
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_hs_valid", out_valid, 0);
    chk("post_hs_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    bit   seen;
    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};

    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {carry, ovf, zero}, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 8; i++) run_op(tbl[i], 0, 1'b0);

    run_op(tbl[0], 10, 1'b1);
    run_op(tbl[6], 0, 1'b0);

    @(negedge clk);
    in_valid = 1'b1;
    a = 16'hABCD;
    b = 16'h1111;
    sub = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_result", result, 0);
    chk("abort_flags", {carry, ovf, zero}, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", seen, 0);
    run_op(tbl[7], 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      v = model(W'($urandom), W'($urandom), 1'($urandom));
      run_op(v, int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
